rvc_fetch_aligner: RTL and testbench

Halfword realignment buffer between instruction memory and decode for mixed 16/32-bit (RVC) streams.
- Accepts naturally aligned fetch words of FETCH_W bits.
- Emits one aligned instruction per cycle with its PC and a compressed flag, including 32-bit instructions that straddle fetch-word boundaries.
- Supports redirect (flush) to any halfword-aligned PC.
- Successor to the fixed 32-bit PC+2/PC+4 fetch path: generalised in fetch width and buffer depth, with decoupled handshakes.

---
 rtl/rvc_align_pkg.sv | 24 ++
 rtl/rvc_hw_queue.sv | 78 +++++++
 rtl/rvc_fetch_aligner.sv | 131 +++++++++++++
 tb/tb_rvc_fetch_aligner.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvc_align_pkg.sv
// Shared types and sizing helpers for the RVC fetch aligner.
package rvc_align_pkg;

    localparam int HW_W = 16;

    typedef logic [HW_W-1:0] hw_t;

    function automatic logic is_rvc(input hw_t hw);
        return hw[1:0] != 2'b11;
    endfunction

    function automatic int fetch_hw(input int fetch_w);
        return fetch_w / HW_W;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int skip_w(input int nhw);
        return (nhw > 1) ? $clog2(nhw) : 1;
    endfunction

endpackage

// File: rtl/rvc_hw_queue.sv
// Circular halfword buffer: multi-halfword push with leading skip, pop of 1 or 2.
module rvc_hw_queue
    import rvc_align_pkg::*;
#(
    parameter int NHW      = 2,
    parameter int DEPTH_HW = 8,
    localparam int PW      = ptr_w(DEPTH_HW),
    localparam int SKW     = skip_w(NHW),
    localparam int CW      = PW + 1
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                push,
    input  logic [NHW*HW_W-1:0] push_data,
    input  logic [SKW-1:0]      push_skip,
    input  logic                pop,
    input  logic                pop_two,
    output hw_t                 hw0,
    output hw_t                 hw1,
    output logic [PW:0]         occupancy
);

    hw_t           mem [DEPTH_HW];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [PW:0]   push_cnt;
    logic [PW:0]   pop_cnt;
    logic [PW-1:0] wr_idx [NHW];
    logic [NHW-1:0] wr_en;

    always_comb begin
        push_cnt = '0;
        if (push) begin
            push_cnt = CW'(NHW) - CW'(push_skip);
        end
    end

    always_comb begin
        pop_cnt = '0;
        if (pop) begin
            pop_cnt = pop_two ? CW'(2) : CW'(1);
        end
    end

    // Skipped halfwords shift the rest down so they pack at wr_ptr.
    always_comb begin
        for (int i = 0; i < NHW; i++) begin
            wr_en[i]  = push && (i >= int'(push_skip));
            wr_idx[i] = wr_ptr + PW'(i) - PW'(push_skip);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_cnt[PW-1:0];
            rd_ptr <= rd_ptr + pop_cnt[PW-1:0];
            count  <= count + push_cnt - pop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NHW; i++) begin
            if (wr_en[i]) begin
                mem[wr_idx[i]] <= push_data[i*HW_W +: HW_W];
            end
        end
    end

    assign hw0       = mem[rd_ptr];
    assign hw1       = mem[rd_ptr + PW'(1)];
    assign occupancy = count;

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Halfword realignment of fetch words into 16/32-bit instructions with PC.
// Define RVC_ALIGN_PERF_EN to add the perf_rvc_cnt/perf_rv32_cnt pop counters.
module rvc_fetch_aligner
    import rvc_align_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter int               FETCH_W      = 32,
    parameter int               DEPTH_HW     = 8,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    localparam int              NHW          = fetch_hw(FETCH_W),
    localparam int              PW           = ptr_w(DEPTH_HW),
    localparam int              SKW          = skip_w(NHW),
    localparam int              CW           = PW + 1,
    localparam int              AB           = $clog2(FETCH_W / 8)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [XLEN-1:0]    flush_pc,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FETCH_W-1:0] in_data,
    input  logic [XLEN-1:0]    in_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic               out_is_rvc,
    output logic [PW:0]        occupancy
`ifdef RVC_ALIGN_PERF_EN
    ,
    output logic [31:0]        perf_rvc_cnt,
    output logic [31:0]        perf_rv32_cnt
`endif
);

    hw_t             hw0;
    hw_t             hw1;
    logic [PW:0]     occ;
    logic [PW:0]     free;
    logic [XLEN-1:0] head_pc;
    logic [SKW-1:0]  skip;
    logic            blocked;
    logic            head_rvc;
    logic            push;
    logic            pop;
    logic            unused_ok;

    assign blocked  = reset || flush;
    assign free     = CW'(DEPTH_HW) - occ;
    assign in_ready = !blocked && (free >= CW'(NHW));
    assign push     = in_valid && in_ready;
    assign head_rvc = is_rvc(hw0);

    // Empty check comes first so an unwritten head slot never decides validity.
    assign out_valid = !blocked && (occ != '0)
                       && (head_rvc || (occ >= CW'(2)));
    assign pop       = out_valid && out_ready;

    rvc_hw_queue #(
        .NHW      (NHW),
        .DEPTH_HW (DEPTH_HW)
    ) u_queue (
        .clk       (clk),
        .clear     (blocked),
        .push      (push),
        .push_data (in_data),
        .push_skip (skip),
        .pop       (pop),
        .pop_two   (!head_rvc),
        .hw0       (hw0),
        .hw1       (hw1),
        .occupancy (occ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            head_pc <= RESET_VECTOR;
            skip    <= RESET_VECTOR[AB-1:1];
        end else if (flush) begin
            head_pc <= {flush_pc[XLEN-1:1], 1'b0};
            skip    <= flush_pc[AB-1:1];
        end else begin
            if (pop) begin
                head_pc <= head_pc + (head_rvc ? XLEN'(2) : XLEN'(4));
            end
            if (push) begin
                skip <= '0;
            end
        end
    end

    always_comb begin
        out_instr = '0;
        if (out_valid) begin
            out_instr = head_rvc ? {16'h0, hw0} : {hw1, hw0};
        end
    end

    assign out_is_rvc = out_valid && head_rvc;
    assign out_pc     = head_pc;
    assign occupancy  = occ;

`ifdef RVC_ALIGN_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_rvc_cnt  <= '0;
            perf_rv32_cnt <= '0;
        end else if (pop) begin
            if (head_rvc) begin
                perf_rvc_cnt <= perf_rvc_cnt + 32'd1;
            end else begin
                perf_rv32_cnt <= perf_rv32_cnt + 32'd1;
            end
        end
    end
`endif

    assign unused_ok = ^{in_addr, flush_pc[0]};

    a_in_addr_aligned: assert property (
        @(posedge clk) disable iff (reset)
        push |-> (in_addr[AB-1:0] == '0)
    );

    a_occ_bounded: assert property (
        @(posedge clk) disable iff (reset)
        occ <= CW'(DEPTH_HW)
    );

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed bench: 32-bit fetch instance plus a 64-bit fetch instance.
module tb_rvc_fetch_aligner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_flush;
    logic [31:0] a_flush_pc;
    logic        a_in_valid;
    logic        a_in_ready;
    logic [31:0] a_in_data;
    logic [31:0] a_in_addr;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [31:0] a_out_instr;
    logic [31:0] a_out_pc;
    logic        a_out_is_rvc;
    logic [3:0]  a_occ;

    logic        b_flush;
    logic [31:0] b_flush_pc;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [63:0] b_in_data;
    logic [31:0] b_in_addr;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [31:0] b_out_instr;
    logic [31:0] b_out_pc;
    logic        b_out_is_rvc;
    logic [3:0]  b_occ;

`ifdef RVC_ALIGN_PERF_EN
    logic [31:0] a_prvc, a_prv32, b_prvc, b_prv32;
`endif

    int checks = 0;
    int passed = 0;

    logic [31:0] w32   [4] = '{32'h05934529, 32'h952e0140,
                               32'h00c00613, 32'h90029532};
    logic [31:0] e_pc  [6] = '{32'h0, 32'h2, 32'h6, 32'h8, 32'hc, 32'he};
    logic [31:0] e_ins [6] = '{32'h00004529, 32'h01400593, 32'h0000952e,
                               32'h00c00613, 32'h00009532, 32'h00009002};
    logic        e_rvc [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rvc_fetch_aligner #(
        .XLEN(32), .FETCH_W(32), .DEPTH_HW(8), .RESET_VECTOR(32'h0)
    ) u_a (
        .clk(clk), .reset(reset), .flush(a_flush), .flush_pc(a_flush_pc),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_addr(a_in_addr), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_instr(a_out_instr), .out_pc(a_out_pc), .out_is_rvc(a_out_is_rvc),
        .occupancy(a_occ)
`ifdef RVC_ALIGN_PERF_EN
        , .perf_rvc_cnt(a_prvc), .perf_rv32_cnt(a_prv32)
`endif
    );

    rvc_fetch_aligner #(
        .XLEN(32), .FETCH_W(64), .DEPTH_HW(8), .RESET_VECTOR(32'h0)
    ) u_b (
        .clk(clk), .reset(reset), .flush(b_flush), .flush_pc(b_flush_pc),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_addr(b_in_addr), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_instr(b_out_instr), .out_pc(b_out_pc), .out_is_rvc(b_out_is_rvc),
        .occupancy(b_occ)
`ifdef RVC_ALIGN_PERF_EN
        , .perf_rvc_cnt(b_prvc), .perf_rv32_cnt(b_prv32)
`endif
    );

    function automatic logic [15:0] hwv(input int n);
        return 16'(n * 4 + 256);
    endfunction

    function automatic logic [31:0] wv(input int k);
        return {hwv(2 * k + 1), hwv(2 * k)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_flush = 0; a_flush_pc = '0; a_in_valid = 0; a_in_data = '0;
        a_in_addr = '0; a_out_ready = 0;
        b_flush = 0; b_flush_pc = '0; b_in_valid = 0; b_in_data = '0;
        b_in_addr = '0; b_out_ready = 0;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1;
        cyc();
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b0) $display("FAIL rst_in_ready_during got=%0h exp=0", a_in_ready); else passed++;
        cyc();
        reset = 0;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0h exp=1", a_in_ready); else passed++;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0h exp=0", a_out_valid); else passed++;
        checks++; if (a_occ !== 4'd0) $display("FAIL rst_occ got=%0d exp=0", a_occ); else passed++;
        checks++; if (a_out_pc !== 32'h0) $display("FAIL rst_out_pc got=%0h exp=0", a_out_pc); else passed++;
        checks++; if (a_out_instr !== 32'h0) $display("FAIL rst_out_instr got=%0h exp=0", a_out_instr); else passed++;
        checks++; if (a_out_is_rvc !== 1'b0) $display("FAIL rst_out_is_rvc got=%0h exp=0", a_out_is_rvc); else passed++;
        checks++; if (b_in_ready !== 1'b1) $display("FAIL rst_b_in_ready got=%0h exp=1", b_in_ready); else passed++;
        cyc();
    endtask

    task automatic test_stream();
        int  w;
        int  got;
        logic acc;
        w = 0;
        got = 0;
        do_reset();
        a_out_ready = 1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            a_in_valid = (w < 4);
            a_in_data  = w32[w % 4];
            a_in_addr  = 32'(w * 4);
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            if (a_out_valid) begin
                checks++;
                if ({a_out_pc, a_out_instr, a_out_is_rvc} !== {e_pc[got], e_ins[got], e_rvc[got]})
                    $display("FAIL stream_%0d got pc=%0h instr=%0h rvc=%0h exp pc=%0h instr=%0h rvc=%0h",
                             got, a_out_pc, a_out_instr, a_out_is_rvc, e_pc[got], e_ins[got], e_rvc[got]);
                else passed++;
                got++;
            end
            cyc();
            if (acc) w++;
        end
        a_in_valid = 0;
        checks++; if (got !== 6) $display("FAIL stream_count got=%0d exp=6", got); else passed++;
    endtask

    task automatic test_straddle_stall();
        do_reset();
        a_out_ready = 1;
        a_in_valid = 1; a_in_data = w32[0]; a_in_addr = 32'h0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) $display("FAIL lat_no_bypass got=%0h exp=0", a_out_valid); else passed++;
        cyc();
        a_in_valid = 0;
        @(negedge clk);
        checks++; if ({a_out_valid, a_out_instr, a_out_pc} !== {1'b1, 32'h00004529, 32'h0})
            $display("FAIL lat_first got v=%0h i=%0h pc=%0h exp v=1 i=4529 pc=0", a_out_valid, a_out_instr, a_out_pc); else passed++;
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({a_out_valid, a_occ} !== {1'b0, 4'd1})
                $display("FAIL straddle_hold_%0d got v=%0h occ=%0d exp v=0 occ=1", i, a_out_valid, a_occ); else passed++;
            cyc();
        end
        a_in_valid = 1; a_in_data = w32[1]; a_in_addr = 32'h4;
        @(negedge clk);
        cyc();
        a_in_valid = 0;
        @(negedge clk);
        checks++; if ({a_out_valid, a_out_instr, a_out_pc, a_out_is_rvc} !== {1'b1, 32'h01400593, 32'h2, 1'b0})
            $display("FAIL straddle_join got v=%0h i=%0h pc=%0h rvc=%0h exp v=1 i=01400593 pc=2 rvc=0",
                     a_out_valid, a_out_instr, a_out_pc, a_out_is_rvc); else passed++;
        cyc();
    endtask

    task automatic test_backpressure_wrap();
        int  w;
        int  n;
        logic acc;
        logic seen;
        w = 0;
        n = 0;
        seen = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            a_in_valid = 1; a_in_data = wv(w); a_in_addr = 32'(w * 4);
            @(negedge clk);
            acc = a_in_ready;
            cyc();
            if (acc) w++;
        end
        a_in_data = wv(w); a_in_addr = 32'(w * 4);
        @(negedge clk);
        checks++; if (w !== 4) $display("FAIL bp_accepted got=%0d exp=4", w); else passed++;
        checks++; if (a_occ !== 4'd8) $display("FAIL bp_occ_full got=%0d exp=8", a_occ); else passed++;
        checks++; if (a_in_ready !== 1'b0) $display("FAIL bp_in_ready_full got=%0h exp=0", a_in_ready); else passed++;
        cyc();
        a_out_ready = 1;
        for (int c = 0; c < 100 && n < 32; c++) begin
            a_in_valid = (w < 16); a_in_data = wv(w); a_in_addr = 32'(w * 4);
            @(negedge clk);
            if (!seen && a_in_ready) begin
                seen = 1;
                checks++; if (a_occ !== 4'd6) $display("FAIL bp_ready_return_occ got=%0d exp=6", a_occ); else passed++;
            end
            acc = a_in_valid && a_in_ready;
            if (a_out_valid) begin
                checks++;
                if ({a_out_instr, a_out_pc, a_out_is_rvc} !== {16'h0, hwv(n), 32'(2 * n), 1'b1})
                    $display("FAIL wrap_pop_%0d got i=%0h pc=%0h rvc=%0h exp i=%0h pc=%0h rvc=1",
                             n, a_out_instr, a_out_pc, a_out_is_rvc, hwv(n), 2 * n);
                else passed++;
                n++;
            end
            cyc();
            if (acc) w++;
        end
        a_in_valid = 0;
        a_out_ready = 0;
        checks++; if (n !== 32) $display("FAIL wrap_pop_count got=%0d exp=32", n); else passed++;
        checks++; if (seen !== 1'b1) $display("FAIL bp_ready_never_returned got=0 exp=1"); else passed++;
    endtask

    task automatic test_flush_skip();
        do_reset();
        a_flush = 1; a_flush_pc = 32'h6;
        @(negedge clk);
        checks++; if ({a_in_ready, a_out_valid} !== 2'b00) $display("FAIL flush_gate got r=%0h v=%0h exp 0 0", a_in_ready, a_out_valid); else passed++;
        cyc();
        a_flush = 0;
        a_in_valid = 1; a_in_data = w32[1]; a_in_addr = 32'h4;
        @(negedge clk);
        checks++; if ({a_out_pc, a_occ} !== {32'h6, 4'd0}) $display("FAIL flush_state got pc=%0h occ=%0d exp pc=6 occ=0", a_out_pc, a_occ); else passed++;
        cyc();
        a_in_valid = 0;
        a_out_ready = 1;
        @(negedge clk);
        checks++; if ({a_out_valid, a_out_pc, a_out_instr, a_out_is_rvc, a_occ} !== {1'b1, 32'h6, 32'h0000952e, 1'b1, 4'd1})
            $display("FAIL flush_skip_out got v=%0h pc=%0h i=%0h rvc=%0h occ=%0d exp v=1 pc=6 i=952e rvc=1 occ=1",
                     a_out_valid, a_out_pc, a_out_instr, a_out_is_rvc, a_occ); else passed++;
        cyc();
        @(negedge clk);
        checks++; if ({a_occ, a_out_valid, a_out_pc} !== {4'd0, 1'b0, 32'h8})
            $display("FAIL flush_after_pop got occ=%0d v=%0h pc=%0h exp occ=0 v=0 pc=8", a_occ, a_out_valid, a_out_pc); else passed++;
        a_out_ready = 0;
        cyc();
    endtask

    task automatic test_flush_priority();
        do_reset();
        a_in_valid = 1; a_in_data = w32[0]; a_in_addr = 32'h0;
        @(negedge clk);
        cyc();
        a_flush = 1; a_flush_pc = 32'h20; a_out_ready = 1;
        a_in_data = w32[1]; a_in_addr = 32'h4;
        @(negedge clk);
        checks++; if ({a_out_valid, a_in_ready} !== 2'b00) $display("FAIL flushpri_gate got v=%0h r=%0h exp 0 0", a_out_valid, a_in_ready); else passed++;
        cyc();
        a_flush = 0; a_in_valid = 0;
        @(negedge clk);
        checks++; if ({a_occ, a_out_valid, a_out_pc} !== {4'd0, 1'b0, 32'h20})
            $display("FAIL flushpri_next got occ=%0d v=%0h pc=%0h exp occ=0 v=0 pc=20", a_occ, a_out_valid, a_out_pc); else passed++;
        a_out_ready = 0;
        cyc();
    endtask

    task automatic test_fetch64();
        do_reset();
        b_in_valid = 1; b_in_data = 64'h952e0140_05934529; b_in_addr = 32'h0;
        b_out_ready = 1;
        @(negedge clk);
        cyc();
        b_in_valid = 0;
        @(negedge clk);
        checks++; if ({b_out_valid, b_out_pc, b_out_instr, b_out_is_rvc} !== {1'b1, 32'h0, 32'h00004529, 1'b1})
            $display("FAIL f64_0 got v=%0h pc=%0h i=%0h rvc=%0h exp v=1 pc=0 i=4529 rvc=1", b_out_valid, b_out_pc, b_out_instr, b_out_is_rvc); else passed++;
        cyc();
        @(negedge clk);
        checks++; if ({b_out_valid, b_out_pc, b_out_instr, b_out_is_rvc} !== {1'b1, 32'h2, 32'h01400593, 1'b0})
            $display("FAIL f64_1 got v=%0h pc=%0h i=%0h rvc=%0h exp v=1 pc=2 i=01400593 rvc=0", b_out_valid, b_out_pc, b_out_instr, b_out_is_rvc); else passed++;
        cyc();
        @(negedge clk);
        checks++; if ({b_out_valid, b_out_pc, b_out_instr, b_out_is_rvc} !== {1'b1, 32'h6, 32'h0000952e, 1'b1})
            $display("FAIL f64_2 got v=%0h pc=%0h i=%0h rvc=%0h exp v=1 pc=6 i=952e rvc=1", b_out_valid, b_out_pc, b_out_instr, b_out_is_rvc); else passed++;
        cyc();
        @(negedge clk);
        checks++; if ({b_out_valid, b_occ} !== {1'b0, 4'd0}) $display("FAIL f64_drained got v=%0h occ=%0d exp v=0 occ=0", b_out_valid, b_occ); else passed++;
`ifdef RVC_ALIGN_PERF_EN
        checks++; if ({b_prvc, b_prv32} !== {32'd2, 32'd1}) $display("FAIL f64_perf got rvc=%0d rv32=%0d exp 2 1", b_prvc, b_prv32); else passed++;
`endif
        b_out_ready = 0;
        b_flush = 1; b_flush_pc = 32'h6;
        cyc();
        b_flush = 0;
        b_in_valid = 1; b_in_data = 64'h952e0140_05934529; b_in_addr = 32'h0;
        @(negedge clk);
`ifdef RVC_ALIGN_PERF_EN
        checks++; if ({b_prvc, b_prv32} !== {32'd2, 32'd1}) $display("FAIL f64_perf_flush got rvc=%0d rv32=%0d exp 2 1", b_prvc, b_prv32); else passed++;
`endif
        cyc();
        b_in_valid = 0;
        @(negedge clk);
        checks++; if ({b_out_valid, b_out_pc, b_out_instr, b_occ} !== {1'b1, 32'h6, 32'h0000952e, 4'd1})
            $display("FAIL f64_skip3 got v=%0h pc=%0h i=%0h occ=%0d exp v=1 pc=6 i=952e occ=1", b_out_valid, b_out_pc, b_out_instr, b_occ); else passed++;
        cyc();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_straddle_stall();
        test_backpressure_wrap();
        test_flush_skip();
        test_flush_priority();
        test_fetch64();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
